pll_reset_sequencer: RTL and testbench

- Sits between the board PLL and the SoC core.
- Drives the PLL reset, qualifies and filters the PLL lock indication, then releases a staged pair of resets: peripherals first, then the core.
- Retries the PLL start-up on lock timeout, reports a permanent fault after the retry budget is spent, and supports a core-only soft reset.
- Runs on the free-running board clock, so it keeps working while the PLL output is absent.

---
 rtl/pll_reset_sequencer.sv | 163 ++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// PLL start-up and staged reset release sequencer.
// Runs on the free-running board clock; retries PLL start-up on lock timeout.
module pll_reset_sequencer #(
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned LOCK_FILTER_CYCLES  = 64,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 1048576,
    parameter int unsigned STAGE_DELAY_CYCLES  = 32,
    parameter int unsigned MAX_RETRIES         = 3,
    parameter int unsigned RETRY_W             = 4
) (
    input  logic               sys_clock,
    input  logic               reset,
    input  logic               pll_locked,
    input  logic               soft_reset_req,
    output logic               pll_rst,
    output logic               periph_reset,
    output logic               core_reset,
    output logic               ready,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_count
);

    localparam int unsigned DLY_MAX =
        (PLL_RST_CYCLES > STAGE_DELAY_CYCLES) ?
        PLL_RST_CYCLES : STAGE_DELAY_CYCLES;
    localparam int DLY_W = $clog2(DLY_MAX + 1);
    localparam int FLT_W = $clog2(LOCK_FILTER_CYCLES + 1);
    localparam int TMO_W = $clog2(LOCK_TIMEOUT_CYCLES + 1);

    localparam logic [DLY_W-1:0] DLY_SAT   = DLY_W'(DLY_MAX);
    localparam logic [DLY_W-1:0] RST_LAST  = DLY_W'(PLL_RST_CYCLES - 1);
    localparam logic [DLY_W-1:0] STG_LAST  = DLY_W'(STAGE_DELAY_CYCLES - 1);
    localparam logic [FLT_W-1:0] FLT_SAT   = FLT_W'(LOCK_FILTER_CYCLES);
    localparam logic [FLT_W-1:0] FLT_LAST  = FLT_W'(LOCK_FILTER_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_SAT   = TMO_W'(LOCK_TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RTY_MAX = RETRY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_REL_PERIPH,
        S_RUN,
        S_SOFT_RST,
        S_FAULT
    } state_t;

    state_t state_q, state_d;

    logic             lock_m, lock_s;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [FLT_W-1:0] flt_q, flt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [RETRY_W-1:0] retry_d;
    logic pll_rst_d, periph_d, core_d, ready_d, fault_d;

    // Lock is not trusted while the PLL is held in reset, so the
    // synchronizer is flushed then; lock_s rises 2 cycles after release.
    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else if (pll_rst) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= pll_locked;
            lock_s <= lock_m;
        end
    end

    always_comb begin
        state_d = state_q;
        retry_d = retry_count;
        unique case (state_q)
            S_PLL_RST: begin
                if (dly_q == RST_LAST)
                    state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (lock_s && flt_q == FLT_LAST) begin
                    state_d = S_REL_PERIPH;
                end else if (tmo_q == TMO_LAST) begin
                    if (retry_count == RTY_MAX) begin
                        state_d = S_FAULT;
                    end else begin
                        state_d = S_PLL_RST;
                        retry_d = retry_count + 1'b1;
                    end
                end
            end
            S_REL_PERIPH: begin
                if (!lock_s)
                    state_d = S_PLL_RST;
                else if (dly_q == STG_LAST)
                    state_d = S_RUN;
            end
            S_RUN: begin
                if (!lock_s)
                    state_d = S_PLL_RST;
                else if (soft_reset_req)
                    state_d = S_SOFT_RST;
            end
            S_SOFT_RST: begin
                if (!lock_s)
                    state_d = S_PLL_RST;
                else if (dly_q == STG_LAST)
                    state_d = S_RUN;
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_PLL_RST;
        endcase

        if (state_d == S_RUN)
            retry_d = '0;

        dly_d = '0;
        if (state_d == state_q)
            dly_d = (dly_q == DLY_SAT) ? dly_q : dly_q + 1'b1;

        flt_d = '0;
        if (state_q == S_WAIT_LOCK && state_d == S_WAIT_LOCK && lock_s)
            flt_d = (flt_q == FLT_SAT) ? flt_q : flt_q + 1'b1;

        tmo_d = '0;
        if (state_q == S_WAIT_LOCK && state_d == S_WAIT_LOCK)
            tmo_d = (tmo_q == TMO_SAT) ? tmo_q : tmo_q + 1'b1;

        pll_rst_d = (state_d == S_PLL_RST) || (state_d == S_FAULT);
        periph_d  = !((state_d == S_REL_PERIPH) || (state_d == S_RUN) ||
                      (state_d == S_SOFT_RST));
        core_d    = (state_d != S_RUN);
        ready_d   = (state_d == S_RUN);
        fault_d   = (state_d == S_FAULT);
    end

    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_PLL_RST;
            dly_q        <= '0;
            flt_q        <= '0;
            tmo_q        <= '0;
            retry_count  <= '0;
            pll_rst      <= 1'b1;
            periph_reset <= 1'b1;
            core_reset   <= 1'b1;
            ready        <= 1'b0;
            fault        <= 1'b0;
        end else begin
            state_q      <= state_d;
            dly_q        <= dly_d;
            flt_q        <= flt_d;
            tmo_q        <= tmo_d;
            retry_count  <= retry_d;
            pll_rst      <= pll_rst_d;
            periph_reset <= periph_d;
            core_reset   <= core_d;
            ready        <= ready_d;
            fault        <= fault_d;
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small timing parameters.
// Outputs are sampled 1 time unit after the rising edge being checked.
module tb_pll_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pll_locked = 1'b0;
    logic       soft_reset_req = 1'b0;
    logic       pll_rst, periph_reset, core_reset, ready, fault;
    logic [3:0] retry_count;
    logic [4:0] outs;

    int n_checks = 0;
    int n_errors = 0;
    int t = 0;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES(4),
        .LOCK_FILTER_CYCLES(8),
        .LOCK_TIMEOUT_CYCLES(100),
        .STAGE_DELAY_CYCLES(5),
        .MAX_RETRIES(2),
        .RETRY_W(4)
    ) dut (
        .sys_clock(clk),
        .reset(reset),
        .pll_locked(pll_locked),
        .soft_reset_req(soft_reset_req),
        .pll_rst(pll_rst),
        .periph_reset(periph_reset),
        .core_reset(core_reset),
        .ready(ready),
        .fault(fault),
        .retry_count(retry_count)
    );

    always #5 clk = ~clk;

    // {pll_rst, periph_reset, core_reset, ready, fault}
    assign outs = {pll_rst, periph_reset, core_reset, ready, fault};

    task automatic check(input string tag,
                         input logic [7:0] got,
                         input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic to_edge(input int e);
        repeat (e - t) @(posedge clk);
        t = e;
        #1;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_outs", {3'b0, outs}, 8'b11100);
        check("rst_retry", {4'b0, retry_count}, 8'd0);
        @(negedge clk);
        reset = 1'b0;
        t = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // clean start, soft reset, async reset mid-soft-reset
        pll_locked = 1'b1;
        reset_dut();
        to_edge(3);
        check("clean_e3", {3'b0, outs}, 8'b11100);
        to_edge(4);
        check("clean_e4", {3'b0, outs}, 8'b01100);
        to_edge(13);
        check("clean_e13", {3'b0, outs}, 8'b01100);
        to_edge(14);
        check("clean_e14", {3'b0, outs}, 8'b00100);
        to_edge(18);
        check("clean_e18", {3'b0, outs}, 8'b00100);
        to_edge(19);
        check("clean_e19", {3'b0, outs}, 8'b00010);
        check("clean_retry", {4'b0, retry_count}, 8'd0);

        soft_reset_req = 1'b1;
        to_edge(20);
        soft_reset_req = 1'b0;
        check("soft_enter", {3'b0, outs}, 8'b00100);
        to_edge(21);
        soft_reset_req = 1'b1;
        to_edge(22);
        soft_reset_req = 1'b0;
        to_edge(24);
        check("soft_e24", {3'b0, outs}, 8'b00100);
        to_edge(25);
        check("soft_done", {3'b0, outs}, 8'b00010);
        to_edge(26);
        check("soft_ignored", {3'b0, outs}, 8'b00010);
        soft_reset_req = 1'b1;
        to_edge(27);
        soft_reset_req = 1'b0;
        check("soft2_enter", {3'b0, outs}, 8'b00100);
        to_edge(28);
        reset = 1'b1;
        #1;
        check("async_outs", {3'b0, outs}, 8'b11100);
        check("async_retry", {4'b0, retry_count}, 8'd0);

        // lock glitch: lock_s low for one cycle at filter count 6
        reset_dut();
        to_edge(10);
        pll_locked = 1'b0;
        to_edge(11);
        pll_locked = 1'b1;
        to_edge(14);
        check("glitch_e14", {3'b0, outs}, 8'b01100);
        to_edge(20);
        check("glitch_e20", {3'b0, outs}, 8'b01100);
        to_edge(21);
        check("glitch_e21", {3'b0, outs}, 8'b00100);
        to_edge(26);
        check("glitch_run", {3'b0, outs}, 8'b00010);
        check("glitch_retry", {4'b0, retry_count}, 8'd0);

        // lock loss in RUN
        pll_locked = 1'b0;
        t = 0;
        to_edge(2);
        check("loss_e2", {3'b0, outs}, 8'b00010);
        to_edge(3);
        check("loss_e3", {3'b0, outs}, 8'b11100);
        check("loss_retry", {4'b0, retry_count}, 8'd0);
        pll_locked = 1'b1;
        to_edge(6);
        check("loss_e6", {3'b0, outs}, 8'b11100);
        to_edge(7);
        check("loss_e7", {3'b0, outs}, 8'b01100);
        to_edge(16);
        check("loss_e16", {3'b0, outs}, 8'b01100);
        to_edge(17);
        check("loss_e17", {3'b0, outs}, 8'b00100);
        to_edge(22);
        check("loss_run", {3'b0, outs}, 8'b00010);

        // filter and timeout complete on the same edge: filter wins
        pll_locked = 1'b0;
        reset_dut();
        to_edge(94);
        pll_locked = 1'b1;
        to_edge(103);
        check("tie_e103", {3'b0, outs}, 8'b01100);
        to_edge(104);
        check("tie_e104", {3'b0, outs}, 8'b00100);
        check("tie_retry", {4'b0, retry_count}, 8'd0);

        // one timeout, then lock
        pll_locked = 1'b0;
        reset_dut();
        to_edge(103);
        check("to1_e103", {3'b0, outs}, 8'b01100);
        check("to1_r103", {4'b0, retry_count}, 8'd0);
        to_edge(104);
        check("to1_e104", {3'b0, outs}, 8'b11100);
        check("to1_r104", {4'b0, retry_count}, 8'd1);
        pll_locked = 1'b1;
        to_edge(117);
        check("to1_e117", {3'b0, outs}, 8'b01100);
        to_edge(118);
        check("to1_e118", {3'b0, outs}, 8'b00100);
        check("to1_r118", {4'b0, retry_count}, 8'd1);
        to_edge(123);
        check("to1_run", {3'b0, outs}, 8'b00010);
        check("to1_rrun", {4'b0, retry_count}, 8'd0);

        // three timeouts -> fault
        pll_locked = 1'b0;
        reset_dut();
        to_edge(207);
        check("to3_r207", {4'b0, retry_count}, 8'd1);
        to_edge(208);
        check("to3_r208", {4'b0, retry_count}, 8'd2);
        to_edge(311);
        check("to3_e311", {3'b0, outs}, 8'b01100);
        to_edge(312);
        check("to3_fault", {3'b0, outs}, 8'b11101);
        check("to3_rfault", {4'b0, retry_count}, 8'd2);
        pll_locked = 1'b1;
        to_edge(400);
        check("to3_stuck", {3'b0, outs}, 8'b11101);
        reset_dut();
        to_edge(1);
        check("to3_cleared", {3'b0, outs}, 8'b11100);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
